ex_mem_pipe_reg: RTL and testbench
==================================

Name: ex_mem_pipe_reg

Overview:
Parametrised execute-to-memory pipeline register with a valid/ready handshake, stall, flush and an optional two-entry skid buffer.
- Carries ALU result, store data, destination register, PC+4 and control bits from the EX stage to the MEM stage.
- Generalises the fixed EX/MEM flip-flop stage so that hazard logic can stall or squash the stage without corrupting state.
- Upstream side connects to the execute stage outputs; downstream side connects to the memory stage and the hazard unit.

Parameters:
DATA_WIDTH, 32, width of ALU result and store data
ADDRESS_WIDTH, 32, width of PC+4
REG_ADDR_WIDTH, 5, width of destination register index
SKID, 1, 1 = two-entry skid buffer with registered ready_o; 0 = single register with combinational ready_o

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
valid_i  in  1  EX stage holds a valid instruction
ready_o  out  1  stage can accept this cycle
alu_result_i  in  DATA_WIDTH  ALU result (E)
write_data_i  in  DATA_WIDTH  store data (E)
rd_i  in  REG_ADDR_WIDTH  destination register (E)
pc_plus4_i  in  ADDRESS_WIDTH  PC+4 (E)
reg_write_i  in  1  register write enable (E)
result_src_i  in  1  result select (E)
mem_write_i  in  1  data memory write enable (E)
flush_i  in  1  squash all held entries
valid_o  out  1  MEM stage entry valid
ready_i  in  1  MEM stage accepts
alu_result_o  out  DATA_WIDTH  ALU result (M)
write_data_o  out  DATA_WIDTH  store data (M)
rd_o  out  REG_ADDR_WIDTH  destination register (M)
pc_plus4_o  out  ADDRESS_WIDTH  PC+4 (M)
reg_write_o  out  1  register write enable (M), gated by valid_o
result_src_o  out  1  result select (M)
mem_write_o  out  1  memory write enable (M), gated by valid_o

Behaviour:
- Definitions: in_fire = valid_i & ready_o; out_fire = valid_o & ready_i.
- Latency: an accepted entry appears on the outputs on the next rising edge.
- Reset (rst_ni low, asynchronous):
  - state = EMPTY, valid_o = 0.
  - All payload registers, main and skid, = 0.
  - ready_o = 1.
- Strobe gating: reg_write_o and mem_write_o are ANDed with valid_o, so no strobe escapes from an invalid entry. The other outputs show the main register unconditionally.
- SKID=1 states. ready_o = (state != SKID), registered.
  - EMPTY:
    - in_fire: main <= input, go to FULL.
    - otherwise: stay.
  - FULL:
    - in_fire & out_fire: main <= input, stay.
    - in_fire & !out_fire: skid <= input, go to SKID.
    - !in_fire & out_fire: go to EMPTY.
    - otherwise: hold.
  - SKID (ready_o = 0):
    - out_fire: main <= skid, go to FULL.
    - otherwise: hold both.
- SKID=0: single register.
  - ready_o = !valid_o | ready_i, combinational.
  - in_fire loads main and sets valid_o.
  - out_fire & !in_fire clears valid_o.
  - No skid storage is synthesised.
- Flush priority: flush_i beats every other event.
  - Next state = EMPTY and valid_o = 0, whatever valid_i or ready_i is doing.
  - An input offered in the flush cycle is dropped.
  - Payload registers may keep stale data but must not be observable through the gated strobes.
- Ordering: entries leave strictly in acceptance order; none is duplicated or lost except by flush.
- Stall: with ready_i = 0, every output is held bit-stable.
- Reset mid-operation: both entries are discarded immediately and asynchronously; the first edge after release behaves as EMPTY.

Test Plan:
1. Reset then stream: valid_i=1 and ready_i=1 for 4 cycles with alu_result_i = 0x10, 0x20, 0x30, 0x40 -> alu_result_o shows the same sequence one cycle later, valid_o=1 throughout, ready_o stays 1.
2. Backpressure fill (SKID=1): ready_i=0, offer A=0xAA then B=0xBB -> A in main, B in skid, ready_o=0 on the next cycle, C is refused. ready_i=1 -> outputs A, then B, and ready_o returns to 1.
3. Flush with both entries held, valid_i=1 in the same cycle -> next cycle valid_o=0, reg_write_o=0, mem_write_o=0, ready_o=1, offered entry absent.
4. Asynchronous reset asserted mid-cycle while in SKID -> valid_o and every output drop to 0 before the next edge; ready_o=1.
5. Strobe gating: reg_write_i=1 and mem_write_i=1 with valid_i=0 -> reg_write_o and mem_write_o stay 0.
6. SKID=0 build: ready_i=0 with valid_o=1 -> ready_o=0 in the same cycle. Raise ready_i -> ready_o=1 combinationally and pass-through works at full rate.

Source files
------------

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register with valid/ready handshake, stall and flush.
// SKID=1 adds a second entry so ready_o can come straight from a flop.
module ex_mem_pipe_reg #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int SKID           = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic [DATA_WIDTH-1:0]     alu_result_i,
    input  logic [DATA_WIDTH-1:0]     write_data_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_i,
    input  logic [ADDRESS_WIDTH-1:0]  pc_plus4_i,
    input  logic                      reg_write_i,
    input  logic                      result_src_i,
    input  logic                      mem_write_i,
    input  logic                      flush_i,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [DATA_WIDTH-1:0]     alu_result_o,
    output logic [DATA_WIDTH-1:0]     write_data_o,
    output logic [REG_ADDR_WIDTH-1:0] rd_o,
    output logic [ADDRESS_WIDTH-1:0]  pc_plus4_o,
    output logic                      reg_write_o,
    output logic                      result_src_o,
    output logic                      mem_write_o
);

    localparam int PW = 2 * DATA_WIDTH + REG_ADDR_WIDTH + ADDRESS_WIDTH + 3;

    logic [PW-1:0] in_payload;
    logic [PW-1:0] main_q;
    logic          valid_q;
    logic          ready_int;
    logic          in_fire;
    logic          out_fire;
    logic          reg_write_q;
    logic          mem_write_q;

    assign in_payload = {alu_result_i, write_data_i, rd_i, pc_plus4_i,
                         reg_write_i, result_src_i, mem_write_i};

    assign ready_o  = ready_int;
    assign valid_o  = valid_q;
    assign in_fire  = valid_i & ready_int;
    assign out_fire = valid_q & ready_i;

    // Strobes are masked by valid so a stale or flushed entry can never write.
    assign {alu_result_o, write_data_o, rd_o, pc_plus4_o,
            reg_write_q, result_src_o, mem_write_q} = main_q;
    assign reg_write_o = reg_write_q & valid_q;
    assign mem_write_o = mem_write_q & valid_q;

    if (SKID != 0) begin : g_skid
        typedef enum logic [1:0] {
            ST_EMPTY,
            ST_FULL,
            ST_SKID
        } state_t;

        state_t        state_q;
        state_t        state_d;
        logic [PW-1:0] skid_q;
        logic          load_main_in;
        logic          load_main_skid;
        logic          load_skid;

        always_comb begin
            state_d        = state_q;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
            if (flush_i) begin
                state_d = ST_EMPTY;
            end else begin
                case (state_q)
                    ST_EMPTY: begin
                        if (in_fire) begin
                            load_main_in = 1'b1;
                            state_d      = ST_FULL;
                        end
                    end
                    ST_FULL: begin
                        if (in_fire && out_fire) begin
                            load_main_in = 1'b1;
                        end else if (in_fire) begin
                            load_skid = 1'b1;
                            state_d   = ST_SKID;
                        end else if (out_fire) begin
                            state_d = ST_EMPTY;
                        end
                    end
                    ST_SKID: begin
                        if (out_fire) begin
                            load_main_skid = 1'b1;
                            state_d        = ST_FULL;
                        end
                    end
                    default: state_d = ST_EMPTY;
                endcase
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q <= ST_EMPTY;
            end else begin
                state_q <= state_d;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                main_q <= '0;
                skid_q <= '0;
            end else begin
                if (load_main_in) begin
                    main_q <= in_payload;
                end else if (load_main_skid) begin
                    main_q <= skid_q;
                end
                if (load_skid) begin
                    skid_q <= in_payload;
                end
            end
        end

        // ready depends only on the state flop, so no combinational path from ready_i.
        assign valid_q   = (state_q != ST_EMPTY);
        assign ready_int = (state_q != ST_SKID);
    end else begin : g_single
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                valid_q <= 1'b0;
                main_q  <= '0;
            end else if (flush_i) begin
                valid_q <= 1'b0;
            end else if (in_fire) begin
                valid_q <= 1'b1;
                main_q  <= in_payload;
            end else if (out_fire) begin
                valid_q <= 1'b0;
            end
        end

        assign ready_int = ~valid_q | ready_i;
    end

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Self-checking bench: table-driven vectors on the SKID=1 build, hand-written
// sequences for asynchronous reset and for the SKID=0 build.
module tb_ex_mem_pipe_reg;

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic [31:0] alu_in;
    logic [31:0] wdata_in;
    logic [4:0]  rd_in;
    logic [31:0] pc_in;
    logic        rw_in;
    logic        rs_in;
    logic        mw_in;
    logic        flush;
    logic        ready_in;

    logic        s1_ready, s1_valid, s1_rw, s1_rs, s1_mw;
    logic [31:0] s1_alu, s1_wdata, s1_pc;
    logic [4:0]  s1_rd;
    logic        s0_ready, s0_valid, s0_rw, s0_rs, s0_mw;
    logic [31:0] s0_alu, s0_wdata, s0_pc;
    logic [4:0]  s0_rd;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        v;
        logic        r;
        logic        f;
        logic [31:0] alu;
        logic        rw;
        logic        mw;
        logic        ev;
        logic [31:0] ealu;
        logic        erdy;
        logic        erw;
        logic        emw;
        logic        chk;
    } vec_t;

    vec_t vecs[16];

    ex_mem_pipe_reg #(.SKID(1)) dut_skid (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_in), .ready_o(s1_ready),
        .alu_result_i(alu_in), .write_data_i(wdata_in), .rd_i(rd_in),
        .pc_plus4_i(pc_in), .reg_write_i(rw_in), .result_src_i(rs_in),
        .mem_write_i(mw_in), .flush_i(flush), .valid_o(s1_valid),
        .ready_i(ready_in), .alu_result_o(s1_alu), .write_data_o(s1_wdata),
        .rd_o(s1_rd), .pc_plus4_o(s1_pc), .reg_write_o(s1_rw),
        .result_src_o(s1_rs), .mem_write_o(s1_mw)
    );

    ex_mem_pipe_reg #(.SKID(0)) dut_single (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_in), .ready_o(s0_ready),
        .alu_result_i(alu_in), .write_data_i(wdata_in), .rd_i(rd_in),
        .pc_plus4_i(pc_in), .reg_write_i(rw_in), .result_src_i(rs_in),
        .mem_write_i(mw_in), .flush_i(flush), .valid_o(s0_valid),
        .ready_i(ready_in), .alu_result_o(s0_alu), .write_data_o(s0_wdata),
        .rd_o(s0_rd), .pc_plus4_o(s0_pc), .reg_write_o(s0_rw),
        .result_src_o(s0_rs), .mem_write_o(s0_mw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The other payload fields are derived from alu so one value identifies an entry.
    task automatic applyStimulus(input logic v, input logic r, input logic f,
                                 input logic [31:0] alu, input logic rw, input logic mw);
        valid_in = v;
        ready_in = r;
        flush    = f;
        alu_in   = alu;
        wdata_in = ~alu;
        rd_in    = alu[4:0];
        pc_in    = alu + 32'd4;
        rw_in    = rw;
        rs_in    = alu[0];
        mw_in    = mw;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h20, 1'b1, 1'b0, 1'b1, 32'h20, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'h30, 1'b1, 1'b0, 1'b1, 32'h30, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 32'h40, 1'b1, 1'b0, 1'b1, 32'h40, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h99, 1'b1, 1'b0, 1'b0, 32'h40, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h55, 1'b1, 1'b1, 1'b0, 32'h40, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'hAA, 1'b1, 1'b1, 1'b1, 32'hAA, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'hBB, 1'b1, 1'b0, 1'b1, 32'hAA, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'hCC, 1'b1, 1'b1, 1'b1, 32'hAA, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 32'hCC, 1'b1, 1'b1, 1'b1, 32'hBB, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 32'hCC, 1'b1, 1'b1, 1'b0, 32'hBB, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 32'h11, 1'b1, 1'b1, 1'b1, 32'h11, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 32'h22, 1'b1, 1'b0, 1'b1, 32'h11, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 32'h33, 1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 32'h44, 1'b1, 1'b0, 1'b1, 32'h44, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 32'h44, 1'b0, 1'b0, 1'b0, 32'h44, 1'b1, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        #12;
        checkOutput("reset valid", {31'd0, s1_valid}, 32'd0);
        checkOutput("reset ready", {31'd0, s1_ready}, 32'd1);
        checkOutput("reset alu", s1_alu, 32'd0);
        checkOutput("reset pc", s1_pc, 32'd0);
        checkOutput("reset s0 valid", {31'd0, s0_valid}, 32'd0);
        checkOutput("reset s0 ready", {31'd0, s0_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].v, vecs[i].r, vecs[i].f, vecs[i].alu, vecs[i].rw, vecs[i].mw);
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("v%0d valid", i), {31'd0, s1_valid}, {31'd0, vecs[i].ev});
            checkOutput($sformatf("v%0d ready", i), {31'd0, s1_ready}, {31'd0, vecs[i].erdy});
            checkOutput($sformatf("v%0d reg_write", i), {31'd0, s1_rw}, {31'd0, vecs[i].erw});
            checkOutput($sformatf("v%0d mem_write", i), {31'd0, s1_mw}, {31'd0, vecs[i].emw});
            if (vecs[i].chk) begin
                checkOutput($sformatf("v%0d alu", i), s1_alu, vecs[i].ealu);
                checkOutput($sformatf("v%0d wdata", i), s1_wdata, ~vecs[i].ealu);
                checkOutput($sformatf("v%0d pc", i), s1_pc, vecs[i].ealu + 32'd4);
                checkOutput($sformatf("v%0d rd", i), {27'd0, s1_rd}, {27'd0, vecs[i].ealu[4:0]});
                checkOutput($sformatf("v%0d result_src", i), {31'd0, s1_rs}, {31'd0, vecs[i].ealu[0]});
            end
        end

        // Fill both entries, then pull reset low between edges.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h61, 1'b1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h62, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("pre-reset ready", {31'd0, s1_ready}, 32'd0);
        checkOutput("pre-reset alu", s1_alu, 32'h61);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async valid", {31'd0, s1_valid}, 32'd0);
        checkOutput("async ready", {31'd0, s1_ready}, 32'd1);
        checkOutput("async alu", s1_alu, 32'd0);
        checkOutput("async wdata", s1_wdata, 32'd0);
        checkOutput("async pc", s1_pc, 32'd0);
        checkOutput("async rd", {27'd0, s1_rd}, 32'd0);
        checkOutput("async strobes", {30'd0, s1_rw, s1_mw}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h77, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("post-reset valid", {31'd0, s1_valid}, 32'd1);
        checkOutput("post-reset alu", s1_alu, 32'h77);
        checkOutput("post-reset ready", {31'd0, s1_ready}, 32'd1);

        // SKID=0 build: combinational ready and full-rate pass-through.
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'hA1, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("s0 load valid", {31'd0, s0_valid}, 32'd1);
        checkOutput("s0 load alu", s0_alu, 32'hA1);
        checkOutput("s0 stall ready", {31'd0, s0_ready}, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'hA2, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("s0 stall alu", s0_alu, 32'hA1);
        checkOutput("s0 stall valid", {31'd0, s0_valid}, 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'hB1, 1'b1, 1'b1);
        #1;
        checkOutput("s0 comb ready", {31'd0, s0_ready}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("s0 stream%0d alu", k), s0_alu, 32'hB1 + k);
            checkOutput($sformatf("s0 stream%0d valid", k), {31'd0, s0_valid}, 32'd1);
            checkOutput($sformatf("s0 stream%0d ready", k), {31'd0, s0_ready}, 32'd1);
            checkOutput($sformatf("s0 stream%0d mem_write", k), {31'd0, s0_mw}, 32'd1);
            applyStimulus(1'b1, 1'b1, 1'b0, 32'hB2 + k, 1'b1, 1'b1);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 32'hEE, 1'b1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("s0 drain valid", {31'd0, s0_valid}, 32'd0);
        checkOutput("s0 drain strobes", {30'd0, s0_rw, s0_mw}, 32'd0);
        checkOutput("s0 drain ready", {31'd0, s0_ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
